// File: rtl/timer_pkg.sv
// Shared helpers and types for the multi-channel microsecond timer.
package timer_pkg;

    typedef enum logic {
        TMR_ONESHOT = 1'b0,
        TMR_RELOAD  = 1'b1
    } tmr_mode_e;

    function automatic int ticks_per_us(input int clock_f);
        return clock_f / 1_000_000;
    endfunction

    function automatic int cnt_width(input int max_time_us);
        return $clog2(max_time_us + 1);
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Shared 1 us prescaler: one-cycle tick every TICKS_PER_US unpaused clocks.
module us_tick_gen
    import timer_pkg::*;
#(
    parameter int CLOCK_F = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pause,
    output logic tick
);

    localparam int TPU = ticks_per_us(CLOCK_F);
    localparam int PW  = (TPU > 1) ? $clog2(TPU) : 1;
    localparam logic [PW-1:0] LAST = PW'(TPU - 1);

    logic [PW-1:0] count_reg;

    // With TPU == 1 the count sits at 0 == LAST, so every unpaused cycle ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (!pause) begin
            count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
        end
    end

    assign tick = !pause && (count_reg == LAST);

endmodule

// File: rtl/multi_timer.sv
// N_CH independent microsecond down-counters sharing one prescaler, each with
// one-shot / auto-reload modes, restart, abort and a global pause.
module multi_timer
    import timer_pkg::*;
#(
    parameter int CLOCK_F     = 50_000_000,
    parameter int N_CH        = 4,
    parameter int MAX_TIME_US = 10_000_000,
    parameter int CNT_W       = cnt_width(MAX_TIME_US)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pause,
    input  logic [N_CH-1:0]       start,
    input  logic [N_CH-1:0]       stop,
    input  logic [N_CH-1:0]       auto_reload,
    input  logic [N_CH*CNT_W-1:0] period_us,
    output logic [N_CH-1:0]       done,
    output logic [N_CH-1:0]       active,
    output logic [N_CH*CNT_W-1:0] remaining_us
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TIME_US);

    logic tick;

    us_tick_gen #(
        .CLOCK_F(CLOCK_F)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .pause (pause),
        .tick  (tick)
    );

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] load;
        logic [CNT_W-1:0] cnt_reg;
        logic             active_reg;
        logic             done_reg;
        tmr_mode_e        mode;

        assign period = period_us[gi*CNT_W +: CNT_W];
        assign load   = (period > MAX_CNT) ? MAX_CNT : period;
        assign mode   = tmr_mode_e'(auto_reload[gi]);

        // Priority stop > start > tick; a zero load never arms the channel.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg    <= '0;
                active_reg <= 1'b0;
                done_reg   <= 1'b0;
            end else if (stop[gi]) begin
                cnt_reg    <= '0;
                active_reg <= 1'b0;
                done_reg   <= 1'b0;
            end else if (start[gi]) begin
                cnt_reg    <= load;
                active_reg <= (load != '0);
                done_reg   <= (load == '0);
            end else if (tick && active_reg) begin
                if (cnt_reg > CNT_W'(1)) begin
                    cnt_reg  <= cnt_reg - 1'b1;
                    done_reg <= 1'b0;
                end else begin
                    done_reg <= 1'b1;
                    if (mode == TMR_RELOAD && load != '0) begin
                        cnt_reg <= load;
                    end else begin
                        cnt_reg    <= '0;
                        active_reg <= 1'b0;
                    end
                end
            end else begin
                done_reg <= 1'b0;
            end
        end

        assign done[gi]                       = done_reg;
        assign active[gi]                     = active_reg;
        assign remaining_us[gi*CNT_W +: CNT_W] = cnt_reg;
    end

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: directed scenarios plus random traffic,
// all compared against a deadline-based reference model.
module tb_multi_timer;

    localparam int CLOCK_F = 4_000_000;
    localparam int N_CH    = 4;
    localparam int MAX     = 10;
    localparam int CNT_W   = $clog2(MAX + 1);
    localparam int TPU     = CLOCK_F / 1_000_000;
    localparam int VW      = 2 * N_CH + N_CH * CNT_W;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  pause = 1'b0;
    logic [N_CH-1:0]       start = '0;
    logic [N_CH-1:0]       stop = '0;
    logic [N_CH-1:0]       auto_reload = '0;
    logic [N_CH*CNT_W-1:0] period_us = '0;
    logic [N_CH-1:0]       done;
    logic [N_CH-1:0]       active;
    logic [N_CH*CNT_W-1:0] remaining_us;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multi_timer #(
        .CLOCK_F     (CLOCK_F),
        .N_CH        (N_CH),
        .MAX_TIME_US (MAX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pause        (pause),
        .start        (start),
        .stop         (stop),
        .auto_reload  (auto_reload),
        .period_us    (period_us),
        .done         (done),
        .active       (active),
        .remaining_us (remaining_us)
    );

    // Reference model: elapsed microseconds = unpaused cycles / TPU; each armed
    // channel holds an absolute deadline in microseconds.
    int u_m;
    int dl_m [N_CH];
    bit arm_m [N_CH];
    bit dn_m [N_CH];

    function automatic int ticks_next();
        return (u_m + (pause ? 0 : 1)) / TPU;
    endfunction

    function automatic int load_of(input int c);
        int p;
        p = int'(period_us[c*CNT_W +: CNT_W]);
        return (p > MAX) ? MAX : p;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_m <= 0;
            for (int c = 0; c < N_CH; c++) begin
                dl_m[c]  <= 0;
                arm_m[c] <= 1'b0;
                dn_m[c]  <= 1'b0;
            end
        end else begin
            u_m <= u_m + (pause ? 0 : 1);
            for (int c = 0; c < N_CH; c++) begin
                if (stop[c]) begin
                    arm_m[c] <= 1'b0;
                    dn_m[c]  <= 1'b0;
                end else if (start[c]) begin
                    arm_m[c] <= (load_of(c) != 0);
                    dn_m[c]  <= (load_of(c) == 0);
                    dl_m[c]  <= ticks_next() + load_of(c);
                end else if (arm_m[c] && ticks_next() == dl_m[c]) begin
                    dn_m[c] <= 1'b1;
                    if (auto_reload[c] && load_of(c) != 0) dl_m[c] <= dl_m[c] + load_of(c);
                    else arm_m[c] <= 1'b0;
                end else begin
                    dn_m[c] <= 1'b0;
                end
            end
        end
    end

    logic [VW-1:0] exp_vec;
    always_comb begin
        exp_vec = '0;
        for (int c = 0; c < N_CH; c++) begin
            exp_vec[N_CH*CNT_W + N_CH + c] = dn_m[c];
            exp_vec[N_CH*CNT_W + c]        = arm_m[c];
            if (arm_m[c]) exp_vec[c*CNT_W +: CNT_W] = CNT_W'(dl_m[c] - u_m / TPU);
        end
    end

    task automatic set_period(input int c, input int p);
        period_us[c*CNT_W +: CNT_W] = CNT_W'(p);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({done, active, remaining_us} !== '0) begin
            n_err++;
            $display("FAIL reset_state got=%h want=0", {done, active, remaining_us});
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            n_vec++;
            if ({done, active, remaining_us} !== exp_vec) begin
                n_err++;
                $display("FAIL reset_idle got=%h want=%h", {done, active, remaining_us}, exp_vec);
            end
        end
    endtask

    task automatic test_oneshot();
        int t_done, n_done, last_rem, rem;
        bit seq_ok;
        set_period(0, 3);
        auto_reload[0] = 1'b0;
        start[0] = 1'b1;
        t_done = -1; n_done = 0; last_rem = 3; seq_ok = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            start[0] = 1'b0;
            n_vec++;
            if ({done, active, remaining_us} !== exp_vec) begin
                n_err++;
                $display("FAIL oneshot_model i=%0d got=%h want=%h", i, {done, active, remaining_us}, exp_vec);
            end
            if (done[0]) begin
                n_done++;
                if (t_done < 0) t_done = i;
                n_vec++;
                if (active[0] !== 1'b0) begin
                    n_err++;
                    $display("FAIL oneshot_active_fall i=%0d active=%b want=0", i, active[0]);
                end
            end
            rem = int'(remaining_us[0 +: CNT_W]);
            if (rem != last_rem) begin
                if (rem != last_rem - 1) seq_ok = 1'b0;
                last_rem = rem;
            end
        end
        n_vec++;
        if (n_done != 1 || t_done < 10 || t_done > 13) begin
            n_err++;
            $display("FAIL oneshot_latency dones=%0d at=%0d want one done in 10..13", n_done, t_done);
        end
        n_vec++;
        if (!seq_ok || last_rem != 0) begin
            n_err++;
            $display("FAIL oneshot_remaining last=%0d seq_ok=%0d want 3,2,1,0", last_rem, seq_ok);
        end
    endtask

    task automatic test_reload();
        int times[$];
        int i;
        set_period(1, 2);
        auto_reload[1] = 1'b1;
        start[1] = 1'b1;
        i = 0;
        while (times.size() < 8 && i < 120) begin
            @(negedge clk);
            i++;
            start[1] = 1'b0;
            n_vec++;
            if ({done, active, remaining_us} !== exp_vec) begin
                n_err++;
                $display("FAIL reload_model i=%0d got=%h want=%h", i, {done, active, remaining_us}, exp_vec);
            end
            if (done[1]) begin
                times.push_back(i);
                if (times.size() == 6) set_period(1, 5);
            end
        end
        n_vec++;
        if (times.size() < 8) begin
            n_err++;
            $display("FAIL reload_timeout dones=%0d want 8", times.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_vec++;
                if (times[k+1] - times[k] != 8) begin
                    n_err++;
                    $display("FAIL reload_spacing k=%0d got=%0d want=8", k, times[k+1] - times[k]);
                end
            end
            n_vec++;
            if (times[6] - times[5] != 8 || times[7] - times[6] != 20) begin
                n_err++;
                $display("FAIL reload_newperiod got=%0d,%0d want=8,20", times[6] - times[5], times[7] - times[6]);
            end
        end
        stop[1] = 1'b1;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            stop[1] = 1'b0;
            n_vec++;
            if (done[1] !== 1'b0 || active[1] !== 1'b0) begin
                n_err++;
                $display("FAIL reload_stop j=%0d done=%b active=%b want 0,0", j, done[1], active[1]);
            end
        end
    endtask

    task automatic test_zero_and_clamp();
        set_period(2, 0);
        auto_reload[2] = 1'b1;
        start[2] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start[2] = 1'b0;
            n_vec++;
            if (done[2] !== (i == 1) || active[2] !== 1'b0) begin
                n_err++;
                $display("FAIL zero_period i=%0d done=%b active=%b want %0d,0", i, done[2], active[2], i == 1);
            end
        end
        set_period(3, MAX + 5);
        auto_reload[3] = 1'b0;
        start[3] = 1'b1;
        @(negedge clk);
        start[3] = 1'b0;
        n_vec++;
        if (remaining_us[3*CNT_W +: CNT_W] !== CNT_W'(MAX) || active[3] !== 1'b1) begin
            n_err++;
            $display("FAIL clamp got=%0d active=%b want=%0d,1", remaining_us[3*CNT_W +: CNT_W], active[3], MAX);
        end
        stop[3] = 1'b1;
        @(negedge clk);
        stop[3] = 1'b0;
    endtask

    task automatic test_collisions();
        bit found;
        // Restart ch2 exactly in its expiry cycle.
        set_period(2, 3);
        auto_reload[2] = 1'b0;
        start[2] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            start = '0;
            n_vec++;
            if ({done, active, remaining_us} !== exp_vec) begin
                n_err++;
                $display("FAIL collide_model i=%0d got=%h want=%h", i, {done, active, remaining_us}, exp_vec);
            end
            if (arm_m[2] && (dl_m[2] - u_m / TPU) == 1 && ((u_m + 1) % TPU) == 0) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL collide_start_timeout got=none want=expiry");
        end else begin
            start[2] = 1'b1;
            @(negedge clk);
            start[2] = 1'b0;
            if (done[2] !== 1'b0 || active[2] !== 1'b1 || remaining_us[2*CNT_W +: CNT_W] !== CNT_W'(3)) begin
                n_err++;
                $display("FAIL collide_start done=%b active=%b rem=%0d want 0,1,3", done[2], active[2], remaining_us[2*CNT_W +: CNT_W]);
            end
        end
        // Abort ch3 exactly in its expiry cycle.
        stop[2] = 1'b1;
        set_period(3, 2);
        auto_reload[3] = 1'b1;
        start[3] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            start = '0;
            stop = '0;
            if (arm_m[3] && (dl_m[3] - u_m / TPU) == 1 && ((u_m + 1) % TPU) == 0) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL collide_stop_timeout got=none want=expiry");
        end else begin
            stop[3] = 1'b1;
            for (int j = 0; j < 12; j++) begin
                @(negedge clk);
                stop[3] = 1'b0;
                n_vec++;
                if (done[3] !== 1'b0 || active[3] !== 1'b0 || remaining_us[3*CNT_W +: CNT_W] !== '0) begin
                    n_err++;
                    $display("FAIL collide_stop j=%0d done=%b active=%b want 0,0", j, done[3], active[3]);
                end
            end
        end
        // All channels started together with period 1 must expire together.
        for (int c = 0; c < N_CH; c++) set_period(c, 1);
        auto_reload = '0;
        start = '1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            start = '0;
            if (|done) begin
                found = 1'b1;
                n_vec++;
                if (done !== '1) begin
                    n_err++;
                    $display("FAIL collide_all got=%b want=%b", done, {N_CH{1'b1}});
                end
            end
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL collide_all_timeout got=none want=done");
        end
    endtask

    task automatic test_pause();
        int u0, want_i, i, got_i;
        logic [CNT_W-1:0] held;
        repeat (3) @(negedge clk);
        set_period(0, 4);
        auto_reload[0] = 1'b0;
        u0 = u_m;
        want_i = TPU * ((u0 + 1) / TPU + 4) - u0 + 37;
        start[0] = 1'b1;
        got_i = -1;
        held = '0;
        for (i = 1; i <= 80 && got_i < 0; i++) begin
            @(negedge clk);
            start[0] = 1'b0;
            n_vec++;
            if ({done, active, remaining_us} !== exp_vec) begin
                n_err++;
                $display("FAIL pause_model i=%0d got=%h want=%h", i, {done, active, remaining_us}, exp_vec);
            end
            if (i == 6) begin
                held = remaining_us[0 +: CNT_W];
                pause = 1'b1;
            end else if (i > 6 && i <= 43) begin
                if (i == 43) pause = 1'b0;
                n_vec++;
                if (remaining_us[0 +: CNT_W] !== held) begin
                    n_err++;
                    $display("FAIL pause_frozen i=%0d got=%0d want=%0d", i, remaining_us[0 +: CNT_W], held);
                end
            end
            if (done[0]) got_i = i;
        end
        n_vec++;
        if (got_i != want_i) begin
            n_err++;
            $display("FAIL pause_delay got=%0d want=%0d", got_i, want_i);
        end
    endtask

    task automatic test_reset_midcount();
        for (int c = 0; c < N_CH; c++) set_period(c, 5);
        auto_reload = '1;
        start = '1;
        @(negedge clk);
        start = '0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({done, active, remaining_us} !== '0) begin
            n_err++;
            $display("FAIL reset_async got=%h want=0", {done, active, remaining_us});
        end
        auto_reload = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            n_vec++;
            if (done !== '0 || {done, active, remaining_us} !== exp_vec) begin
                n_err++;
                $display("FAIL reset_spurious j=%0d got=%h want=%h", j, {done, active, remaining_us}, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            n_vec++;
            if ({done, active, remaining_us} !== exp_vec) begin
                n_err++;
                $display("FAIL random_model i=%0d got=%h want=%h", i, {done, active, remaining_us}, exp_vec);
            end
            pause = ($urandom_range(0, 9) == 0);
            for (int c = 0; c < N_CH; c++) begin
                start[c] = ($urandom_range(0, 15) == 0);
                stop[c]  = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 7) == 0) auto_reload[c] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 5) == 0) set_period(c, int'($urandom_range(0, MAX + 3)));
            end
        end
        start = '0;
        stop = '0;
        pause = 1'b0;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_reload();
        test_zero_and_clamp();
        test_collisions();
        test_pause();
        test_reset_midcount();
        test_oneshot();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
